// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin mem-protocol arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One requester's request fields, carried through the winner mux as a unit.
  typedef struct packed {
    logic [MEM_ADDR_W-1:0]   addr;
    logic                    we;
    logic [MEM_DATA_W-1:0]   wdata;
    logic [MEM_DATA_W/8-1:0] be;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_idx_fifo.sv
// In-order FIFO of requester indices, one entry per granted but unanswered request.
module mem_arb_idx_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap by compare-and-clear so non-power-of-2 depths work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one mem master port among NUM_REQ requesters;
// responses are routed back in order through an index FIFO, with no added latency.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MEM_ADDR_WIDTH  = MEM_ADDR_W,
  parameter int MEM_DATA_WIDTH  = MEM_DATA_W,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  s_mem_req,
  output logic [NUM_REQ-1:0]                  s_mem_gnt,
  input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0]   s_mem_addr,
  input  logic [NUM_REQ-1:0]                  s_mem_we,
  input  logic [NUM_REQ*MEM_DATA_WIDTH-1:0]   s_mem_wdata,
  input  logic [NUM_REQ*MEM_DATA_WIDTH/8-1:0] s_mem_be,
  output logic [NUM_REQ-1:0]                  s_mem_valid,
  output logic [NUM_REQ*MEM_DATA_WIDTH-1:0]   s_mem_rdata,
  output logic [NUM_REQ-1:0]                  s_mem_error,
  output logic                                m_mem_req,
  input  logic                                m_mem_gnt,
  output logic [MEM_ADDR_WIDTH-1:0]           m_mem_addr,
  output logic                                m_mem_we,
  output logic [MEM_DATA_WIDTH-1:0]           m_mem_wdata,
  output logic [MEM_DATA_WIDTH/8-1:0]         m_mem_be,
  input  logic                                m_mem_valid,
  input  logic [MEM_DATA_WIDTH-1:0]           m_mem_rdata,
  input  logic                                m_mem_error,
  output logic                                unexpected_rsp_o
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int BW = MEM_DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_idx;
  logic          lock_valid;
  logic [IW-1:0] winner;
  logic [IW-1:0] head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          accept;
  logic          rsp_ok;
  mem_req_t      sel;

  // A locked winner keeps the bridge's view stable while it withholds grant.
  always_comb begin
    logic [IW-1:0] cand;
    logic          found;
    int            pos;
    cand   = '0;
    found  = 1'b0;
    pos    = 0;
    winner = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IW'(pos);
      if (!found && s_mem_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    if (lock_valid) winner = lock_idx;
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IW'(i)) begin
        sel.addr  = s_mem_addr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        sel.we    = s_mem_we[i];
        sel.wdata = s_mem_wdata[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
        sel.be    = s_mem_be[i*BW +: BW];
      end
    end
  end

  assign m_mem_req   = (|s_mem_req) & ~full;
  assign m_mem_addr  = sel.addr;
  assign m_mem_we    = sel.we;
  assign m_mem_wdata = sel.wdata;
  assign m_mem_be    = sel.be;
  assign accept      = m_mem_req & m_mem_gnt;
  assign rsp_ok      = m_mem_valid & (count != '0);

  always_comb begin
    s_mem_gnt = '0;
    if (accept) s_mem_gnt[winner] = 1'b1;
  end

  always_comb begin
    s_mem_valid = '0;
    s_mem_rdata = '0;
    s_mem_error = '0;
    if (rsp_ok) s_mem_valid[head] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_mem_rdata[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = s_mem_valid[i] ? m_mem_rdata : '0;
      s_mem_error[i] = s_mem_valid[i] & m_mem_error;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr           <= '0;
      lock_valid       <= 1'b0;
      lock_idx         <= '0;
      unexpected_rsp_o <= 1'b0;
    end else begin
      if (accept) begin
        lock_valid <= 1'b0;
        rr_ptr     <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
      end else if (m_mem_req) begin
        lock_valid <= 1'b1;
        lock_idx   <= winner;
      end
      if (m_mem_valid && empty) unexpected_rsp_o <= 1'b1;
    end
  end

  mem_arb_idx_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_idx_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (accept),
    .push_data (winner),
    .pop       (m_mem_valid),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed grant checks plus an
// in-order response scoreboard filled at grant time.
module tb_mem_rr_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    s_mem_req;
  logic [NR-1:0]    s_mem_gnt;
  logic [NR*AW-1:0] s_mem_addr;
  logic [NR-1:0]    s_mem_we;
  logic [NR*DW-1:0] s_mem_wdata;
  logic [NR*BW-1:0] s_mem_be;
  logic [NR-1:0]    s_mem_valid;
  logic [NR*DW-1:0] s_mem_rdata;
  logic [NR-1:0]    s_mem_error;
  logic             m_mem_req;
  logic             m_mem_gnt;
  logic [AW-1:0]    m_mem_addr;
  logic             m_mem_we;
  logic [DW-1:0]    m_mem_wdata;
  logic [BW-1:0]    m_mem_be;
  logic             m_mem_valid;
  logic [DW-1:0]    m_mem_rdata;
  logic             m_mem_error;
  logic             unexpected_rsp;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t br_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   serial = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(
    .NUM_REQ         (NR),
    .MEM_ADDR_WIDTH  (AW),
    .MEM_DATA_WIDTH  (DW),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .s_mem_req        (s_mem_req),
    .s_mem_gnt        (s_mem_gnt),
    .s_mem_addr       (s_mem_addr),
    .s_mem_we         (s_mem_we),
    .s_mem_wdata      (s_mem_wdata),
    .s_mem_be         (s_mem_be),
    .s_mem_valid      (s_mem_valid),
    .s_mem_rdata      (s_mem_rdata),
    .s_mem_error      (s_mem_error),
    .m_mem_req        (m_mem_req),
    .m_mem_gnt        (m_mem_gnt),
    .m_mem_addr       (m_mem_addr),
    .m_mem_we         (m_mem_we),
    .m_mem_wdata      (m_mem_wdata),
    .m_mem_be         (m_mem_be),
    .m_mem_valid      (m_mem_valid),
    .m_mem_rdata      (m_mem_rdata),
    .m_mem_error      (m_mem_error),
    .unexpected_rsp_o (unexpected_rsp)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // A response pops the bridge-side queue so data leaves in grant order.
  task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rsp);
    exp_t b;
    s_mem_req   = req;
    m_mem_gnt   = gnt;
    m_mem_valid = rsp;
    m_mem_rdata = '0;
    m_mem_error = 1'b0;
    if (rsp) begin
      if (br_q.size() > 0) begin
        b = br_q.pop_front();
        m_mem_rdata = b.rdata;
        m_mem_error = b.err;
      end else begin
        m_mem_rdata = 32'hBAD0_BAD0;
      end
    end
  endtask

  task automatic expectGrant(input int port, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
    br_q.push_back(e);
    serial++;
  endtask

  task automatic applyReset();
    s_mem_req   = '0;
    m_mem_gnt   = 1'b0;
    m_mem_valid = 1'b0;
    m_mem_rdata = '0;
    m_mem_error = 1'b0;
    rst_n       = 1'b0;
    exp_q.delete();
    br_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Every bridge response must land on the oldest granted requester.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_mem_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("stray_valid", 64'(s_mem_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("rsp_valid", 64'(s_mem_valid), 64'(1) << mon_e.port);
          checkOutput("rsp_rdata", 64'(s_mem_rdata), 64'(mon_e.rdata) << (32 * mon_e.port));
          checkOutput("rsp_error", 64'(s_mem_error), mon_e.err ? (64'(1) << mon_e.port) : 64'(0));
        end
      end else if (s_mem_valid !== '0) begin
        checkOutput("valid_without_rsp", 64'(s_mem_valid), 64'(0));
      end
    end
  end

  initial begin
    s_mem_addr  = {32'h0000_2000, 32'h0000_1000};
    s_mem_we    = 2'b10;
    s_mem_wdata = {32'hCAFE_0001, 32'h0000_0000};
    s_mem_be    = {4'h3, 4'hF};
    s_mem_req   = '0;
    m_mem_gnt   = 1'b0;
    m_mem_valid = 1'b0;
    m_mem_rdata = '0;
    m_mem_error = 1'b0;
    rst_n       = 1'b0;

    sample();
    checkOutput("rst_gnt", 64'(s_mem_gnt), 64'(0));
    checkOutput("rst_valid", 64'(s_mem_valid), 64'(0));
    checkOutput("rst_mreq", 64'(m_mem_req), 64'(0));
    checkOutput("rst_unexp", 64'(unexpected_rsp), 64'(0));
    nextCycle();
    rst_n = 1'b1;

    // Single requester read, answered two cycles after the grant.
    applyStimulus(2'b01, 1'b1, 1'b0);
    sample();
    checkOutput("t1_gnt", 64'(s_mem_gnt), 64'(2'b01));
    checkOutput("t1_addr", 64'(m_mem_addr), 64'h1000);
    checkOutput("t1_we", 64'(m_mem_we), 64'(0));
    expectGrant(0, 1'b0, 32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b1);
    sample();
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0);

    // Fairness with same-cycle push/pop: grants alternate starting at 0.
    applyReset();
    for (int g = 0; g < 8; g++) begin
      applyStimulus(2'b11, 1'b1, g > 0);
      sample();
      checkOutput("t2_gnt", 64'(s_mem_gnt), 64'(1) << (g % 2));
      checkOutput("t2_addr", 64'(m_mem_addr), (g % 2) ? 64'h2000 : 64'h1000);
      if (g % 2 == 1) begin
        checkOutput("t2_we", 64'(m_mem_we), 64'(1));
        checkOutput("t2_wdata", 64'(m_mem_wdata), 64'hCAFE_0001);
        checkOutput("t2_be", 64'(m_mem_be), 64'h3);
      end
      expectGrant(g % 2, 1'b0, 32'hA500_0000 + 32'(serial));
      nextCycle();
    end
    applyStimulus(2'b00, 1'b0, 1'b1);
    sample();
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0);

    // Backpressure lock: pointer favours 1, but the stalled request from 0 stays locked.
    applyReset();
    applyStimulus(2'b01, 1'b1, 1'b0);
    sample();
    checkOutput("t3_pre_gnt", 64'(s_mem_gnt), 64'(2'b01));
    expectGrant(0, 1'b0, 32'h1111_0000);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b1);
    sample();
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b01, 1'b0, 1'b0);
      sample();
      checkOutput("t3_hold_addr", 64'(m_mem_addr), 64'h1000);
      checkOutput("t3_hold_gnt", 64'(s_mem_gnt), 64'(0));
      nextCycle();
    end
    applyStimulus(2'b11, 1'b0, 1'b0);
    sample();
    checkOutput("t3_lock_addr", 64'(m_mem_addr), 64'h1000);
    nextCycle();
    applyStimulus(2'b11, 1'b1, 1'b0);
    sample();
    checkOutput("t3_lock_gnt", 64'(s_mem_gnt), 64'(2'b01));
    expectGrant(0, 1'b0, 32'h1111_0001);
    nextCycle();
    applyStimulus(2'b10, 1'b1, 1'b0);
    sample();
    checkOutput("t3_next_gnt", 64'(s_mem_gnt), 64'(2'b10));
    expectGrant(1, 1'b0, 32'h1111_0002);
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b1);
      sample();
      nextCycle();
    end
    applyStimulus(2'b00, 1'b0, 1'b0);

    // Full stall: two outstanding blocks the port; a pop unblocks only next cycle.
    applyReset();
    applyStimulus(2'b11, 1'b1, 1'b0);
    sample();
    checkOutput("t4_gnt0", 64'(s_mem_gnt), 64'(2'b01));
    expectGrant(0, 1'b0, 32'h2222_0000);
    nextCycle();
    applyStimulus(2'b11, 1'b1, 1'b0);
    sample();
    checkOutput("t4_gnt1", 64'(s_mem_gnt), 64'(2'b10));
    expectGrant(1, 1'b0, 32'h2222_0001);
    nextCycle();
    applyStimulus(2'b11, 1'b1, 1'b0);
    sample();
    checkOutput("t4_full_mreq", 64'(m_mem_req), 64'(0));
    checkOutput("t4_full_gnt", 64'(s_mem_gnt), 64'(0));
    nextCycle();
    applyStimulus(2'b11, 1'b1, 1'b1);
    sample();
    checkOutput("t4_pop_mreq", 64'(m_mem_req), 64'(0));
    checkOutput("t4_pop_gnt", 64'(s_mem_gnt), 64'(0));
    nextCycle();
    applyStimulus(2'b11, 1'b1, 1'b0);
    sample();
    checkOutput("t4_resume_gnt", 64'(s_mem_gnt), 64'(2'b01));
    expectGrant(0, 1'b0, 32'h2222_0002);
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b1);
      sample();
      nextCycle();
    end
    applyStimulus(2'b00, 1'b0, 1'b0);

    // Error response to requester 1, then a stray response with nothing outstanding.
    applyReset();
    applyStimulus(2'b10, 1'b1, 1'b0);
    sample();
    checkOutput("t5_gnt", 64'(s_mem_gnt), 64'(2'b10));
    expectGrant(1, 1'b1, 32'h3333_0000);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b1);
    sample();
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b1);
    sample();
    checkOutput("t5_unexp_before", 64'(unexpected_rsp), 64'(0));
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0);
    sample();
    checkOutput("t5_unexp_set", 64'(unexpected_rsp), 64'(1));
    repeat (3) nextCycle();
    sample();
    checkOutput("t5_unexp_sticky", 64'(unexpected_rsp), 64'(1));
    applyReset();
    sample();
    checkOutput("t5_unexp_cleared", 64'(unexpected_rsp), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
